// File: rtl/lcd_spi_pkg.sv
// Shared constants and decoder state encoding for the LCD SPI link monitor.
package lcd_spi_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_RASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    localparam int unsigned DEF_XE_C = 239;
    localparam int unsigned DEF_YE_C = 319;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CASET = 2'd1,
        ST_RASET = 2'd2,
        ST_RAMWR = 2'd3
    } dec_state_t;

endpackage

// File: rtl/lcd_spi_monitor_if.sv
// 4-wire LCD SPI link: the write block drives it as master, the monitor listens as slave.
interface lcd_spi_monitor_if;

    logic cs;
    logic dc;
    logic sclk;
    logic mosi;

    modport master (output cs, dc, sclk, mosi);
    modport slave  (input  cs, dc, sclk, mosi);

endinterface

// File: rtl/lcd_spi_monitor_spi_rx_deser.sv
// SPI mode-0 byte deserialiser: input synchronisers, sclk edge detect, shift register,
// bit counter and fragment detection on cs release.
module spi_rx_deser #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    lcd_spi_monitor_if.slave        i_spi,
    output logic                    o_byte_valid,
    output logic [7:0]              o_byte_data,
    output logic                    o_byte_is_data,
    output logic                    o_frag_err
);

    localparam int unsigned SYNC_W = 4;
    localparam int unsigned CNT_W  = 3;
    // cs synchronises to its idle (deselected) level out of reset
    localparam logic [SYNC_W-1:0] SYNC_RST = 4'b1000;

    logic [SYNC_STAGES-1:0][SYNC_W-1:0] r_sync;
    logic                               r_sclk_d;
    logic [6:0]                         r_shift;
    logic [CNT_W-1:0]                   r_bit_cnt;

    logic w_cs;
    logic w_dc;
    logic w_sclk;
    logic w_mosi;
    logic w_sclk_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{SYNC_RST}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], {i_spi.cs, i_spi.dc, i_spi.sclk, i_spi.mosi}};
        end
    end

    assign {w_cs, w_dc, w_sclk, w_mosi} = r_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_d       <= 1'b0;
            r_shift        <= '0;
            r_bit_cnt      <= '0;
            o_byte_valid   <= 1'b0;
            o_byte_data    <= '0;
            o_byte_is_data <= 1'b0;
            o_frag_err     <= 1'b0;
        end else begin
            r_sclk_d     <= w_sclk;
            o_byte_valid <= 1'b0;
            o_frag_err   <= 1'b0;
            if (w_cs) begin
                // Partial byte is dropped; counter is only non-zero with 1..7 bits in
                r_bit_cnt  <= '0;
                o_frag_err <= (r_bit_cnt != '0);
            end else if (w_sclk_rise) begin
                r_shift   <= {r_shift[5:0], w_mosi};
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                if (r_bit_cnt == CNT_W'(7)) begin
                    o_byte_valid   <= 1'b1;
                    o_byte_data    <= {r_shift, w_mosi};
                    o_byte_is_data <= w_dc;
                end
            end
        end
    end

endmodule

// File: rtl/lcd_spi_monitor.sv
// LCD SPI link monitor: tags received bytes, decodes CASET/RASET/RAMWR and
// reassembles RGB565 pixels with their window coordinates.
module lcd_spi_monitor
    import lcd_spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned COORD_W     = 9,
    parameter int unsigned DEF_XE      = DEF_XE_C,
    parameter int unsigned DEF_YE      = DEF_YE_C
) (
    input  logic               clk,
    input  logic               rst_n,
    lcd_spi_monitor_if.slave   i_spi,
    output logic               o_byte_valid,
    output logic [7:0]         o_byte_data,
    output logic               o_byte_is_data,
    output logic [7:0]         o_last_cmd,
    output logic [COORD_W-1:0] o_x_start,
    output logic [COORD_W-1:0] o_x_end,
    output logic [COORD_W-1:0] o_y_start,
    output logic [COORD_W-1:0] o_y_end,
    output logic               o_pixel_valid,
    output logic [15:0]        o_pixel_data,
    output logic [COORD_W-1:0] o_pixel_x,
    output logic [COORD_W-1:0] o_pixel_y,
    output logic               o_frame_done,
    output logic               o_frag_err
);

    dec_state_t         r_state,       w_state_nx;
    logic [1:0]         r_param_idx,   w_param_idx_nx;
    logic [7:0]         r_par0,        w_par0_nx;
    logic [7:0]         r_par1,        w_par1_nx;
    logic [7:0]         r_par2,        w_par2_nx;
    logic               r_phase_lo,    w_phase_lo_nx;
    logic [7:0]         r_hi_byte,     w_hi_byte_nx;
    logic [7:0]         r_last_cmd,    w_last_cmd_nx;
    logic [COORD_W-1:0] r_x_start,     w_x_start_nx;
    logic [COORD_W-1:0] r_x_end,       w_x_end_nx;
    logic [COORD_W-1:0] r_y_start,     w_y_start_nx;
    logic [COORD_W-1:0] r_y_end,       w_y_end_nx;
    logic [COORD_W-1:0] r_pixel_x,     w_pixel_x_nx;
    logic [COORD_W-1:0] r_pixel_y,     w_pixel_y_nx;
    logic [15:0]        r_pixel_data,  w_pixel_data_nx;
    logic               r_pixel_valid, w_pixel_valid_nx;
    logic               r_frame_done,  w_frame_done_nx;

    spi_rx_deser #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_spi          (i_spi),
        .o_byte_valid   (o_byte_valid),
        .o_byte_data    (o_byte_data),
        .o_byte_is_data (o_byte_is_data),
        .o_frag_err     (o_frag_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_param_idx   <= '0;
            r_par0        <= '0;
            r_par1        <= '0;
            r_par2        <= '0;
            r_phase_lo    <= 1'b0;
            r_hi_byte     <= '0;
            r_last_cmd    <= '0;
            r_x_start     <= '0;
            r_x_end       <= COORD_W'(DEF_XE);
            r_y_start     <= '0;
            r_y_end       <= COORD_W'(DEF_YE);
            r_pixel_x     <= '0;
            r_pixel_y     <= '0;
            r_pixel_data  <= '0;
            r_pixel_valid <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_param_idx   <= w_param_idx_nx;
            r_par0        <= w_par0_nx;
            r_par1        <= w_par1_nx;
            r_par2        <= w_par2_nx;
            r_phase_lo    <= w_phase_lo_nx;
            r_hi_byte     <= w_hi_byte_nx;
            r_last_cmd    <= w_last_cmd_nx;
            r_x_start     <= w_x_start_nx;
            r_x_end       <= w_x_end_nx;
            r_y_start     <= w_y_start_nx;
            r_y_end       <= w_y_end_nx;
            r_pixel_x     <= w_pixel_x_nx;
            r_pixel_y     <= w_pixel_y_nx;
            r_pixel_data  <= w_pixel_data_nx;
            r_pixel_valid <= w_pixel_valid_nx;
            r_frame_done  <= w_frame_done_nx;
        end
    end

    always_comb begin
        w_state_nx       = r_state;
        w_param_idx_nx   = r_param_idx;
        w_par0_nx        = r_par0;
        w_par1_nx        = r_par1;
        w_par2_nx        = r_par2;
        w_phase_lo_nx    = r_phase_lo;
        w_hi_byte_nx     = r_hi_byte;
        w_last_cmd_nx    = r_last_cmd;
        w_x_start_nx     = r_x_start;
        w_x_end_nx       = r_x_end;
        w_y_start_nx     = r_y_start;
        w_y_end_nx       = r_y_end;
        w_pixel_x_nx     = r_pixel_x;
        w_pixel_y_nx     = r_pixel_y;
        w_pixel_data_nx  = r_pixel_data;
        w_pixel_valid_nx = 1'b0;
        w_frame_done_nx  = 1'b0;

        // Coordinates step the cycle after the pixel was presented with them
        if (r_pixel_valid) begin
            if (r_pixel_x >= r_x_end) begin
                w_pixel_x_nx = r_x_start;
                w_pixel_y_nx = (r_pixel_y >= r_y_end) ? r_y_start : r_pixel_y + COORD_W'(1);
            end else begin
                w_pixel_x_nx = r_pixel_x + COORD_W'(1);
            end
        end

        if (o_byte_valid) begin
            if (!o_byte_is_data) begin
                w_last_cmd_nx  = o_byte_data;
                w_param_idx_nx = '0;
                w_phase_lo_nx  = 1'b0;
                case (o_byte_data)
                    CMD_CASET: w_state_nx = ST_CASET;
                    CMD_RASET: w_state_nx = ST_RASET;
                    CMD_RAMWR: begin
                        w_state_nx   = ST_RAMWR;
                        w_pixel_x_nx = r_x_start;
                        w_pixel_y_nx = r_y_start;
                    end
                    default:   w_state_nx = ST_IDLE;
                endcase
            end else begin
                case (r_state)
                    ST_CASET, ST_RASET: begin
                        w_param_idx_nx = r_param_idx + 2'd1;
                        case (r_param_idx)
                            2'd0:    w_par0_nx = o_byte_data;
                            2'd1:    w_par1_nx = o_byte_data;
                            2'd2:    w_par2_nx = o_byte_data;
                            default: begin
                                w_state_nx = ST_IDLE;
                                if (r_state == ST_CASET) begin
                                    w_x_start_nx = COORD_W'({r_par0, r_par1});
                                    w_x_end_nx   = COORD_W'({r_par2, o_byte_data});
                                end else begin
                                    w_y_start_nx = COORD_W'({r_par0, r_par1});
                                    w_y_end_nx   = COORD_W'({r_par2, o_byte_data});
                                end
                            end
                        endcase
                    end
                    ST_RAMWR: begin
                        if (!r_phase_lo) begin
                            w_hi_byte_nx  = o_byte_data;
                            w_phase_lo_nx = 1'b1;
                        end else begin
                            w_pixel_data_nx  = {r_hi_byte, o_byte_data};
                            w_pixel_valid_nx = 1'b1;
                            w_phase_lo_nx    = 1'b0;
                            w_frame_done_nx  = (r_pixel_x >= r_x_end) && (r_pixel_y >= r_y_end);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_last_cmd    = r_last_cmd;
    assign o_x_start     = r_x_start;
    assign o_x_end       = r_x_end;
    assign o_y_start     = r_y_start;
    assign o_y_end       = r_y_end;
    assign o_pixel_valid = r_pixel_valid;
    assign o_pixel_data  = r_pixel_data;
    assign o_pixel_x     = r_pixel_x;
    assign o_pixel_y     = r_pixel_y;
    assign o_frame_done  = r_frame_done;

endmodule

// File: tb/tb_lcd_spi_monitor.sv
// Directed bench for lcd_spi_monitor: byte/command vector table plus pixel, fragment and reset sequences.
module tb_lcd_spi_monitor;

    localparam int unsigned COORD_W = 9;
    localparam int unsigned HALF    = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lcd_spi_monitor_if spi_bus();

    logic               o_byte_valid, o_byte_is_data, o_pixel_valid, o_frame_done, o_frag_err;
    logic [7:0]         o_byte_data, o_last_cmd;
    logic [15:0]        o_pixel_data;
    logic [COORD_W-1:0] o_x_start, o_x_end, o_y_start, o_y_end, o_pixel_x, o_pixel_y;

    lcd_spi_monitor #(
        .SYNC_STAGES (2),
        .COORD_W     (COORD_W),
        .DEF_XE      (239),
        .DEF_YE      (319)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_spi          (spi_bus),
        .o_byte_valid   (o_byte_valid),
        .o_byte_data    (o_byte_data),
        .o_byte_is_data (o_byte_is_data),
        .o_last_cmd     (o_last_cmd),
        .o_x_start      (o_x_start),
        .o_x_end        (o_x_end),
        .o_y_start      (o_y_start),
        .o_y_end        (o_y_end),
        .o_pixel_valid  (o_pixel_valid),
        .o_pixel_data   (o_pixel_data),
        .o_pixel_x      (o_pixel_x),
        .o_pixel_y      (o_pixel_y),
        .o_frame_done   (o_frame_done),
        .o_frag_err     (o_frag_err)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       is_data;
    } byte_rec_t;

    typedef struct packed {
        logic [15:0]        data;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               fd;
    } pix_rec_t;

    typedef struct {
        logic               dc;
        logic [7:0]         b;
        logic [7:0]         cmd;
        logic [COORD_W-1:0] xs, xe, ys, ye;
    } vec_t;

    byte_rec_t byte_q[$];
    pix_rec_t  pix_q[$];
    int        frag_cnt   = 0;
    int        fd_orphans = 0;
    int        n_cmp      = 0;
    int        n_err      = 0;
    vec_t      vecs[12];

    // Capture DUT pulses on the falling edge
    always @(negedge clk) begin
        if (o_byte_valid) byte_q.push_back({o_byte_data, o_byte_is_data});
        if (o_pixel_valid) pix_q.push_back({o_pixel_data, o_pixel_x, o_pixel_y, o_frame_done});
        if (o_frag_err) frag_cnt++;
        if (o_frame_done && !o_pixel_valid) fd_orphans++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic dc, input logic [7:0] b, input int n);
        spi_bus.cs = 1'b0;
        spi_bus.dc = dc;
        for (int i = 7; i > 7 - n; i--) begin
            spi_bus.mosi = b[i];
            tick(HALF);
            spi_bus.sclk = 1'b1;
            tick(HALF);
            spi_bus.sclk = 1'b0;
        end
        tick(HALF);
    endtask

    task automatic send_byte(input logic dc, input logic [7:0] b);
        send_bits(dc, b, 8);
    endtask

    task automatic cs_pulse();
        spi_bus.cs = 1'b1;
        tick(6);
        spi_bus.cs = 1'b0;
        tick(4);
    endtask

    task automatic expect_byte(input string name, input logic [7:0] d, input logic isd);
        byte_rec_t r;
        int t = 0;
        while (byte_q.size() == 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (byte_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: no byte_valid within 40 cycles, want 0x%0h", name, d);
        end else begin
            r = byte_q.pop_front();
            chk({name, ".data"}, 32'(r.data), 32'(d));
            chk({name, ".is_data"}, 32'(r.is_data), 32'(isd));
        end
    endtask

    task automatic expect_pixel(input string name, input logic [15:0] d,
                                input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y,
                                input logic fd);
        pix_rec_t r;
        int t = 0;
        while (pix_q.size() == 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (pix_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: no pixel_valid within 40 cycles, want 0x%0h", name, d);
        end else begin
            r = pix_q.pop_front();
            chk({name, ".data"}, 32'(r.data), 32'(d));
            chk({name, ".x"}, 32'(r.x), 32'(x));
            chk({name, ".y"}, 32'(r.y), 32'(y));
            chk({name, ".frame_done"}, 32'(r.fd), 32'(fd));
        end
    endtask

    task automatic check_reset(input string p);
        chk({p, ".byte_valid"},   32'(o_byte_valid),   32'(0));
        chk({p, ".byte_data"},    32'(o_byte_data),    32'(0));
        chk({p, ".byte_is_data"}, 32'(o_byte_is_data), 32'(0));
        chk({p, ".last_cmd"},     32'(o_last_cmd),     32'(0));
        chk({p, ".x_start"},      32'(o_x_start),      32'(0));
        chk({p, ".x_end"},        32'(o_x_end),        32'(239));
        chk({p, ".y_start"},      32'(o_y_start),      32'(0));
        chk({p, ".y_end"},        32'(o_y_end),        32'(319));
        chk({p, ".pixel_valid"},  32'(o_pixel_valid),  32'(0));
        chk({p, ".pixel_data"},   32'(o_pixel_data),   32'(0));
        chk({p, ".pixel_x"},      32'(o_pixel_x),      32'(0));
        chk({p, ".pixel_y"},      32'(o_pixel_y),      32'(0));
        chk({p, ".frame_done"},   32'(o_frame_done),   32'(0));
        chk({p, ".frag_err"},     32'(o_frag_err),     32'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(3);
        byte_q.delete();
        pix_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int frag_base;

        spi_bus.cs   = 1'b1;
        spi_bus.dc   = 1'b0;
        spi_bus.sclk = 1'b0;
        spi_bus.mosi = 1'b0;

        vecs[0]  = '{1'b0, 8'h11, 8'h11, 9'd0,  9'd239, 9'd0, 9'd319};
        vecs[1]  = '{1'b0, 8'h2A, 8'h2A, 9'd0,  9'd239, 9'd0, 9'd319};
        vecs[2]  = '{1'b1, 8'h00, 8'h2A, 9'd0,  9'd239, 9'd0, 9'd319};
        vecs[3]  = '{1'b1, 8'h0A, 8'h2A, 9'd0,  9'd239, 9'd0, 9'd319};
        vecs[4]  = '{1'b1, 8'h00, 8'h2A, 9'd0,  9'd239, 9'd0, 9'd319};
        vecs[5]  = '{1'b1, 8'h0B, 8'h2A, 9'd10, 9'd11,  9'd0, 9'd319};
        vecs[6]  = '{1'b1, 8'h55, 8'h2A, 9'd10, 9'd11,  9'd0, 9'd319};
        vecs[7]  = '{1'b0, 8'h2B, 8'h2B, 9'd10, 9'd11,  9'd0, 9'd319};
        vecs[8]  = '{1'b1, 8'h02, 8'h2B, 9'd10, 9'd11,  9'd0, 9'd319};
        vecs[9]  = '{1'b1, 8'h05, 8'h2B, 9'd10, 9'd11,  9'd0, 9'd319};
        vecs[10] = '{1'b1, 8'h00, 8'h2B, 9'd10, 9'd11,  9'd0, 9'd319};
        vecs[11] = '{1'b1, 8'h07, 8'h2B, 9'd10, 9'd11,  9'd5, 9'd7};

        tick(3);
        check_reset("rst");
        rst_n = 1'b1;
        tick(3);

        // Byte tagging and window decode table
        for (int i = 0; i < 12; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            send_byte(vecs[i].dc, vecs[i].b);
            expect_byte(nm, vecs[i].b, vecs[i].dc);
            chk({nm, ".last_cmd"}, 32'(o_last_cmd), 32'(vecs[i].cmd));
            chk({nm, ".x_start"},  32'(o_x_start),  32'(vecs[i].xs));
            chk({nm, ".x_end"},    32'(o_x_end),    32'(vecs[i].xe));
            chk({nm, ".y_start"},  32'(o_y_start),  32'(vecs[i].ys));
            chk({nm, ".y_end"},    32'(o_y_end),    32'(vecs[i].ye));
        end
        chk("table.extra_bytes", 32'(byte_q.size()), 32'(0));
        chk("table.no_pixels", 32'(pix_q.size()), 32'(0));

        // 2x2 window raster, with a cs toggle between the halves of the fifth pixel
        byte_q.delete();
        send_byte(1'b0, 8'h2A); send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h00);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h01);
        send_byte(1'b0, 8'h2B); send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h00);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h01);
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'h12); send_byte(1'b1, 8'h34);
        send_byte(1'b1, 8'h56); send_byte(1'b1, 8'h78);
        send_byte(1'b1, 8'h9A); send_byte(1'b1, 8'hBC);
        send_byte(1'b1, 8'hDE); send_byte(1'b1, 8'hF0);
        send_byte(1'b1, 8'h11);
        cs_pulse();
        send_byte(1'b1, 8'h22);
        expect_pixel("pix0", 16'h1234, 9'd0, 9'd0, 1'b0);
        expect_pixel("pix1", 16'h5678, 9'd1, 9'd0, 1'b0);
        expect_pixel("pix2", 16'h9ABC, 9'd0, 9'd1, 1'b0);
        expect_pixel("pix3", 16'hDEF0, 9'd1, 9'd1, 1'b1);
        expect_pixel("pix4", 16'h1122, 9'd0, 9'd0, 1'b0);
        chk("raster.extra_pixels", 32'(pix_q.size()), 32'(0));
        chk("raster.no_frag", 32'(frag_cnt), 32'(0));

        // Fragment: 5 bits then cs high, then a clean RAMWR byte
        byte_q.delete();
        frag_base = frag_cnt;
        send_bits(1'b0, 8'hFF, 5);
        cs_pulse();
        chk("frag.count", 32'(frag_cnt - frag_base), 32'(1));
        chk("frag.no_byte", 32'(byte_q.size()), 32'(0));
        send_byte(1'b0, 8'h2C);
        expect_byte("frag.next", 8'h2C, 1'b0);
        chk("frag.count_after", 32'(frag_cnt - frag_base), 32'(1));

        // Aborted CASET leaves the default window in place
        do_reset();
        send_byte(1'b0, 8'h2A); send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h05);
        send_byte(1'b0, 8'h2C);
        chk("abort.x_start", 32'(o_x_start), 32'(0));
        chk("abort.x_end", 32'(o_x_end), 32'(239));
        chk("abort.last_cmd", 32'(o_last_cmd), 32'(8'h2C));
        send_byte(1'b1, 8'hAB); send_byte(1'b1, 8'hCD);
        expect_pixel("abort.pix", 16'hABCD, 9'd0, 9'd0, 1'b0);

        // Single-pixel window, then reset in the middle of a byte
        send_byte(1'b0, 8'h2A); send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h05);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h05);
        send_byte(1'b0, 8'h2B); send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h07);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h07);
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'hF8); send_byte(1'b1, 8'h00);
        expect_pixel("single.pix", 16'hF800, 9'd5, 9'd7, 1'b1);
        tick(2);
        chk("single.wrap_x", 32'(o_pixel_x), 32'(5));
        chk("single.wrap_y", 32'(o_pixel_y), 32'(7));
        send_bits(1'b0, 8'hFF, 4);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        tick(3);
        rst_n = 1'b1;
        tick(3);
        byte_q.delete();
        pix_q.delete();
        send_byte(1'b0, 8'hA5);
        expect_byte("postrst", 8'hA5, 1'b0);
        chk("postrst.last_cmd", 32'(o_last_cmd), 32'(8'hA5));
        chk("fd_orphans", 32'(fd_orphans), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
